// File: rtl/param_signal_generator_if.sv
// ============================================================================
// Module  : param_signal_generator_if
// Purpose : Control and sample bundle for the multi-mode waveform generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface param_signal_generator_if #(
    parameter int W = 5
);
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] amp;
    logic [W-1:0] wave;
    logic         period_start;
    logic [1:0]   mode_active;

    modport master (
        output en, mode, amp,
        input  wave, period_start, mode_active
    );

    modport slave (
        input  en, mode, amp,
        output wave, period_start, mode_active
    );
endinterface

`default_nettype wire

// File: rtl/param_signal_generator.sv
// ============================================================================
// Module  : param_signal_generator
// Purpose : Square/sawtooth/triangle generator with phase-aligned mode and
//           amplitude changes and an immediate hold mode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module param_signal_generator #(
    parameter int W       = 5,
    parameter int MAX_AMP = 20,
    parameter int HALF    = 10
) (
    input  wire logic                clk,
    input  wire logic                rst,
    param_signal_generator_if.slave  sig
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam int               CNT_W    = $clog2(2 * HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HALF);
    localparam logic [W-1:0]     AMP_MAX  = W'(MAX_AMP);
    localparam logic [W-1:0]     ONE      = W'(1);

    mode_t            cur_mode;
    logic [W-1:0]     amp_r;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             first;
    logic [W-1:0]     wave;
    logic             period_start;

    logic [W-1:0]     amp_clip;
    logic             boundary;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = cnt + 1'b1;

    always_comb begin
        amp_clip = sig.amp;
        if (sig.amp == '0)
            amp_clip = ONE;
        else if (sig.amp > AMP_MAX)
            amp_clip = AMP_MAX;
    end

    // A boundary edge is one whose next sample is the 0 that opens a period.
    always_comb begin
        boundary = 1'b0;
        case (cur_mode)
            MODE_SQUARE: boundary = (cnt == CNT_LAST);
            MODE_SAW:    boundary = (wave == amp_r);
            MODE_TRI:    boundary = dir ? (wave == ONE)
                                        : ((wave == amp_r) && (amp_r == ONE));
            MODE_HOLD:   boundary = (sig.mode != 2'd3);
            default:     boundary = 1'b0;
        endcase
        if (first)
            boundary = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mode     <= MODE_SQUARE;
            amp_r        <= ONE;
            cnt          <= '0;
            dir          <= 1'b0;
            first        <= 1'b1;
            wave         <= '0;
            period_start <= 1'b0;
        end else if (!sig.en) begin
            period_start <= 1'b0;
        end else if (boundary) begin
            cur_mode     <= mode_t'(sig.mode);
            amp_r        <= amp_clip;
            cnt          <= '0;
            dir          <= 1'b0;
            first        <= 1'b0;
            wave         <= '0;
            period_start <= 1'b1;
        end else begin
            period_start <= 1'b0;
            if (sig.mode == 2'd3) begin
                cur_mode <= MODE_HOLD;
            end else begin
                case (cur_mode)
                    MODE_SQUARE: begin
                        cnt  <= cnt_next;
                        wave <= (cnt_next >= CNT_HIGH) ? amp_r : '0;
                    end
                    MODE_SAW: begin
                        wave <= wave + ONE;
                    end
                    MODE_TRI: begin
                        if (dir) begin
                            wave <= wave - ONE;
                        end else if (wave == amp_r) begin
                            dir  <= 1'b1;
                            wave <= wave - ONE;
                        end else begin
                            wave <= wave + ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sig.wave         = wave;
    assign sig.period_start = period_start;
    assign sig.mode_active  = cur_mode;

endmodule

`default_nettype wire

// File: doc/param_signal_generator.md
# param_signal_generator

Parametrised multi-mode waveform generator. It produces square, sawtooth and triangle waveforms on a W-bit registered output, and amplitude is selectable at run time. Mode and amplitude changes are phase-aligned: they take effect only at a period boundary, except for the hold mode, which freezes the output immediately. It sits in the signal-source path feeding DAC/test-pattern logic and replaces the fixed 5-bit, fixed-amplitude generator.

## Interface
- W, 5, output width in bits.
- MAX_AMP, 20, largest permitted peak value; must be ≤ 2^W−1 and ≥ 1.
- HALF, 10, square-wave half period in cycles; must be ≥ 1.

- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset; priority over every other input.
- en  input  1  advance enable; when low, all state holds.
- mode  input  2  0 = square, 1 = sawtooth, 2 = triangle, 3 = hold.
- amp  input  W  requested peak value, clipped on latch.
- wave  output  W  registered waveform sample.
- period_start  output  1  one-cycle pulse, high in the cycle `wave` shows the first sample (0) of a new period.
- mode_active  output  2  mode currently in effect (latched copy).

## Operation
- Internal state:
  - `cur_mode`, the active mode.
  - `amp_r`, the latched peak.
  - `cnt`, the square phase counter, range 0..2·HALF−1.
  - `dir`, the triangle direction (0 = up).
  - `first`, set by reset.
- Clip rule on latch: `amp_r` = 1 if amp = 0; MAX_AMP if amp > MAX_AMP; otherwise amp.
- Boundary edge: the edge that loads `wave` ← 0 as the start of a period. On this edge:
  - `cur_mode` ← mode and `amp_r` ← clip(amp);
  - `cnt` ← 0 and `dir` ← up;
  - `period_start` ← 1.
  - On all other edges, `period_start` ← 0.
- Boundary edges occur:
  - on the first en=1 edge after reset (`first` set, then cleared);
  - in square mode, when `cnt` wraps from 2·HALF−1;
  - in sawtooth mode, on the edge after `wave` = `amp_r`;
  - in triangle mode, when descending `wave` = 1 steps to 0;
  - on the first edge where mode ≠ 3 is sampled while `cur_mode` = 3.
- Square:
  - `wave` = 0 for `cnt` 0..HALF−1 and `amp_r` for `cnt` HALF..2·HALF−1.
  - Period is 2·HALF cycles.
- Sawtooth:
  - Sequence 0, 1, …, `amp_r`, then a boundary.
  - Period is `amp_r`+1 cycles.
- Triangle:
  - Sequence 0, 1, …, `amp_r`, `amp_r`−1, …, 1, then a boundary.
  - Period is 2·`amp_r` cycles.
  - For `amp_r` = 1: 0, 1, 0, 1, …
- Hold:
  - mode = 3 sampled on any en=1 edge gives `cur_mode` ← 3 on that edge, with `wave`, `cnt` and `dir` unchanged.
  - While `cur_mode` = 3, `wave` is frozen.
  - Leaving hold restarts at 0 via a boundary edge.
- Non-hold mode and amp changes outside a boundary are ignored until the next boundary; the current period always completes.
- en = 0: all registers hold and `period_start` ← 0. Resumption continues the same sequence.
- All arithmetic is W-bit unsigned. No wrap beyond `amp_r` is possible by construction.

## Timing
- Reset values: `wave` = 0, `period_start` = 0, `mode_active` = 0, `amp_r` = 1, `cnt` = 0, `dir` = up, `first` = 1.
- Reset asserted mid-period returns everything to reset values on that edge. The waveform restarts on the first en=1 edge after release.
- Latency:
  - mode/amp are sampled on the boundary edge, and the new shape is visible from the same output sample (0).
  - The first nonzero sample of the new mode appears one cycle later (sawtooth/triangle), or HALF cycles later (square).
  - Hold entry: `wave` stops changing from the edge that samples mode = 3.
- `period_start` and `mode_active` update on the same edge as `wave`, with no combinational paths from inputs to outputs.
- Simultaneous boundary and mode = 3: hold wins. `cur_mode` ← 3, `wave` ← 0, `period_start` = 1.

## Test plan
- Square, amp=20 (W=5, MAX_AMP=20, HALF=10):
  - Stimulus: rst 3 cycles, then en=1, mode=0, amp=20.
  - Required: `wave` 0 for 10 cycles, then 20 for 10, repeating.
  - Required: `period_start` every 20 cycles, first on the first edge after release.
- Sawtooth, clipping:
  - amp=5 → 0, 1, 2, 3, 4, 5, 0, period 6.
  - amp changed to 31 mid-ramp → takes effect only after the wrap; next period runs 0..20.
  - amp=0 → 0, 1, 0, 1.
- Triangle, amp=4:
  - Required: 0, 1, 2, 3, 4, 3, 2, 1, 0, with `period_start` every 8 cycles.
  - Switch mode to 1 at `wave`=3 ascending → the triangle completes to 0, then sawtooth begins; `mode_active`=1 on the 0 sample.
- Hold:
  - Sawtooth amp=20; mode=3 at `wave`=7 → `wave` stays 7 and `mode_active`=3.
  - Then mode=2 → next sample 0 with `period_start`=1, followed by 1, 2, …
- Enable gating:
  - Triangle amp=6; en=0 for 5 cycles at `wave`=4 descending → `wave` holds 4 and `period_start` stays 0.
  - Re-enable → continues 3, 2, 1, 0.
- Reset mid-operation:
  - rst at square high phase → `wave`=0, `mode_active`=0, `period_start`=0 on the next edge.
  - Release with mode=1, amp=3 → 0, 1, 2, 3, 0.
